// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC/FWH cycle decoder: bus codes, record status
// values, decoder states and the FWH MSIZE decode helper.
package lpc_pkg;

    localparam logic [3:0] START_LPC    = 4'b0000;
    localparam logic [3:0] START_FWH_RD = 4'b1101;
    localparam logic [3:0] START_FWH_WR = 4'b1110;

    localparam logic [1:0] CT_IO  = 2'b00;
    localparam logic [1:0] CT_MEM = 2'b01;

    localparam logic [3:0] SYNC_READY      = 4'b0000;
    localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
    localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
    localparam logic [3:0] SYNC_ERROR      = 4'b1010;

    localparam logic [1:0] STATUS_OK       = 2'd0;
    localparam logic [1:0] STATUS_SYNC_ERR = 2'd1;
    localparam logic [1:0] STATUS_TIMEOUT  = 2'd2;
    localparam logic [1:0] STATUS_ABORT    = 2'd3;

    localparam int SHIFT_NIBBLES = 8;

    typedef enum logic [3:0] {
        IDLE,
        CTDIR,
        FWH_IDSEL,
        ADDR,
        MSIZE,
        DATA,
        TAR1,
        SYNC,
        TAR2
    } lpc_state_t;

    // Returns the FWH transfer length in bytes, or 0 for an unsupported MSIZE.
    function automatic logic [3:0] msize_to_bytes(input logic [3:0] msize);
        case (msize)
            4'b0000: return 4'd1;
            4'b0001: return 4'd2;
            4'b0010: return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/lpc_nibble_shift.sv
// Loadable 32-bit nibble collector: MSB-first shifting for addresses, or
// LSB-first slot filling for data, with a count of nibbles taken.
module lpc_nibble_shift
    import lpc_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic        lsb_first,
    input  logic [3:0]  nibble,
    output logic [31:0] value,
    output logic [3:0]  count
);

    // Count saturates at eight so a stray extra nibble cannot wrap the slot index.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            value <= '0;
            count <= '0;
        end else if (shift) begin
            if (lsb_first) begin
                if (count != 4'(SHIFT_NIBBLES)) begin
                    value[{count[2:0], 2'b00} +: 4] <= nibble;
                end
            end else begin
                value <= {value[27:0], nibble};
            end
            if (count != 4'(SHIFT_NIBBLES)) begin
                count <= count + 4'd1;
            end
        end
    end

endmodule

// File: rtl/lpc_cycle_decoder.sv
// Passive LPC/FWH cycle decoder: follows IO, memory and firmware-hub cycles on
// the bus and emits one status-tagged record per terminated cycle.
module lpc_cycle_decoder
    import lpc_pkg::*;
#(
    parameter int unsigned MAX_BYTES  = 4,
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned ENABLE_FWH = 1
) (
    input  logic                   lpc_clock,
    input  logic                   lpc_reset,
    input  logic [3:0]             lpc_ad,
    input  logic                   lpc_frame,
    output logic [3:0]             out_cyctype_dir,
    output logic [31:0]            out_addr,
    output logic [8*MAX_BYTES-1:0] out_data,
    output logic [3:0]             out_data_size,
    output logic [1:0]             out_status,
    output logic                   out_clock_enable
);

    localparam int unsigned DATA_W       = 8 * MAX_BYTES;
    localparam logic [7:0]  WAIT_LIMIT_W = 8'(WAIT_LIMIT);
    localparam logic [3:0]  MAX_BYTES_W  = 4'(MAX_BYTES);

    lpc_state_t  state, state_next;
    logic [3:0]  cand, ct_dir, idsel, addr_len, size;
    logic        is_fwh, is_write, sync_err, tar_cnt;
    logic [7:0]  wait_cnt;
    logic        start_edge, addr_shift, data_shift, wait_inc, sync_err_set, rec_valid;
    logic [1:0]  rec_status;
    logic [31:0] addr_value, data_value;
    logic [3:0]  addr_count, data_count, msize_bytes, data_last;

    assign msize_bytes = msize_to_bytes(lpc_ad);
    assign data_last   = {size[2:0], 1'b0} - 4'd1;

    lpc_nibble_shift u_addr_shift (
        .clock     (lpc_clock),
        .reset     (lpc_reset),
        .clear     (start_edge),
        .shift     (addr_shift),
        .lsb_first (1'b0),
        .nibble    (lpc_ad),
        .value     (addr_value),
        .count     (addr_count)
    );

    lpc_nibble_shift u_data_shift (
        .clock     (lpc_clock),
        .reset     (lpc_reset),
        .clear     (start_edge),
        .shift     (data_shift),
        .lsb_first (1'b1),
        .nibble    (lpc_ad),
        .value     (data_value),
        .count     (data_count)
    );

    always_ff @(posedge lpc_clock) begin
        if (lpc_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // CTDIR and FWH_IDSEL are only entered from a frame-low edge, so frame
    // still low there is a lengthened START rather than an abort.
    always_comb begin
        state_next   = state;
        start_edge   = 1'b0;
        addr_shift   = 1'b0;
        data_shift   = 1'b0;
        wait_inc     = 1'b0;
        sync_err_set = 1'b0;
        rec_valid    = 1'b0;
        rec_status   = STATUS_OK;
        if (!lpc_frame) begin
            start_edge = 1'b1;
            if (state inside {ADDR, MSIZE, DATA, TAR1, SYNC, TAR2}) begin
                rec_valid  = 1'b1;
                rec_status = STATUS_ABORT;
            end
            if (lpc_ad == START_LPC) begin
                state_next = CTDIR;
            end else if ((ENABLE_FWH != 0) &&
                         (lpc_ad == START_FWH_RD || lpc_ad == START_FWH_WR)) begin
                state_next = FWH_IDSEL;
            end else begin
                state_next = IDLE;
            end
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                CTDIR: begin
                    if (lpc_ad[3:2] == CT_IO || lpc_ad[3:2] == CT_MEM) begin
                        state_next = ADDR;
                    end else begin
                        state_next = IDLE;
                    end
                end
                FWH_IDSEL: state_next = ADDR;
                ADDR: begin
                    addr_shift = 1'b1;
                    if (addr_count == addr_len - 4'd1) begin
                        state_next = is_fwh ? MSIZE : (is_write ? DATA : TAR1);
                    end
                end
                MSIZE: begin
                    if (msize_bytes != 4'd0 && msize_bytes <= MAX_BYTES_W) begin
                        state_next = is_write ? DATA : TAR1;
                    end else begin
                        rec_valid  = 1'b1;
                        rec_status = STATUS_ABORT;
                        state_next = IDLE;
                    end
                end
                DATA: begin
                    data_shift = 1'b1;
                    if (data_count == data_last) begin
                        state_next = is_write ? TAR1 : TAR2;
                    end
                end
                TAR1: if (tar_cnt) state_next = SYNC;
                SYNC: begin
                    case (lpc_ad)
                        SYNC_READY: state_next = is_write ? TAR2 : DATA;
                        SYNC_SHORT_WAIT: begin
                            if (wait_cnt >= WAIT_LIMIT_W) begin
                                rec_valid  = 1'b1;
                                rec_status = STATUS_TIMEOUT;
                                state_next = IDLE;
                            end else begin
                                wait_inc = 1'b1;
                            end
                        end
                        SYNC_LONG_WAIT: state_next = SYNC;
                        SYNC_ERROR: begin
                            sync_err_set = 1'b1;
                            state_next   = is_write ? TAR2 : DATA;
                        end
                        default: begin
                            rec_valid  = 1'b1;
                            rec_status = STATUS_SYNC_ERR;
                            state_next = IDLE;
                        end
                    endcase
                end
                TAR2: begin
                    if (tar_cnt) begin
                        rec_valid  = 1'b1;
                        rec_status = sync_err ? STATUS_SYNC_ERR : STATUS_OK;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Bytes reported are the completed data nibble pairs, so aborts and
    // timeouts before the data phase naturally report zero.
    always_ff @(posedge lpc_clock) begin
        if (lpc_reset) begin
            cand             <= '0;
            ct_dir           <= '0;
            idsel            <= '0;
            addr_len         <= '0;
            size             <= '0;
            is_fwh           <= 1'b0;
            is_write         <= 1'b0;
            sync_err         <= 1'b0;
            tar_cnt          <= 1'b0;
            wait_cnt         <= '0;
            out_cyctype_dir  <= '0;
            out_addr         <= '0;
            out_data         <= '0;
            out_data_size    <= '0;
            out_status       <= '0;
            out_clock_enable <= 1'b0;
        end else begin
            if (start_edge) begin
                cand     <= lpc_ad;
                wait_cnt <= '0;
                sync_err <= 1'b0;
            end
            if (lpc_frame && state == CTDIR) begin
                ct_dir   <= lpc_ad;
                is_fwh   <= 1'b0;
                is_write <= lpc_ad[1];
                addr_len <= (lpc_ad[3:2] == CT_IO) ? 4'd4 : 4'd8;
                size     <= 4'd1;
            end
            if (lpc_frame && state == FWH_IDSEL) begin
                ct_dir   <= cand;
                idsel    <= lpc_ad;
                is_fwh   <= 1'b1;
                is_write <= (cand == START_FWH_WR);
                addr_len <= 4'd7;
            end
            if (lpc_frame && state == MSIZE) begin
                size <= msize_bytes;
            end
            if (wait_inc) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (sync_err_set) begin
                sync_err <= 1'b1;
            end
            tar_cnt          <= (lpc_frame && (state == TAR1 || state == TAR2)) ? ~tar_cnt : 1'b0;
            out_clock_enable <= rec_valid;
            if (rec_valid) begin
                out_cyctype_dir <= ct_dir;
                out_addr        <= is_fwh ? {idsel, addr_value[27:0]} : addr_value;
                out_data        <= data_value[DATA_W-1:0];
                out_data_size   <= {1'b0, data_count[3:1]};
                out_status      <= rec_status;
            end
        end
    end

endmodule

// File: doc/lpc_cycle_decoder.md
Name: lpc_cycle_decoder

Overview:
Passive LPC bus decoder, parametrised successor to the single-byte IO/memory decoder. It decodes IO, memory and firmware-hub (FWH) read/write cycles. It supports multi-byte FWH transfers, short/long waitstates with a timeout, and SYNC errors. It detects aborts (LFRAME# reasserted mid-cycle). Every terminated cycle produces one output record with a status code. It sits between the LPC pins and the sniffer's output FIFO/UART stage.

Parameters:
MAX_BYTES, 4, largest FWH transfer accepted (1, 2 or 4); sets out_data width.
WAIT_LIMIT, 16, consecutive short-wait SYNC nibbles tolerated before timeout (1..255).
ENABLE_FWH, 1, 0 = FWH start codes are ignored (treated as non-start).

Ports:
lpc_clock  in  1  LPC clock; all sampling on rising edge.
lpc_reset  in  1  synchronous, active-high reset.
lpc_ad  in  4  LAD[3:0].
lpc_frame  in  1  LFRAME#, active low.
out_cyctype_dir  out  4  LPC: CT/DIR nibble; FWH: start nibble (1101 read, 1110 write).
out_addr  out  32  zero-extended address (16 IO, 32 mem, {IDSEL,28-bit} FWH).
out_data  out  8*MAX_BYTES  data; byte 0 in bits 7:0; unused bytes 0.
out_data_size  out  4  bytes transferred (0 on abort before data).
out_status  out  2  0 ok, 1 SYNC error, 2 wait timeout, 3 aborted/unsupported.
out_clock_enable  out  1  one-cycle record-valid strobe.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters cleared. Reset mid-cycle discards the cycle with no record.
- START: while lpc_frame=0, lpc_ad is latched as the candidate start. The first cycle with lpc_frame=1 after it selects the path:
  - 0000 → CTDIR.
  - 1101/1110 with ENABLE_FWH → FWH_IDSEL.
  - Anything else → IDLE, no record.
- LPC path: CTDIR, then ADDR.
  - CT 00 (IO): 4 address nibbles. CT 01 (mem): 8 address nibbles. CT 10/11: IDLE, no record.
  - Address nibbles are MSB first.
  - Write: DATA (2 nibbles, low first), TAR (2), SYNC, TAR (2).
  - Read: TAR (2), SYNC, DATA, TAR (2). size = 1.
- FWH path: IDSEL (1), ADDR (7 nibbles), MSIZE (1).
  - MSIZE 0000→1, 0001→2, 0010→4 bytes.
  - Other values, or size > MAX_BYTES → record status 3, then IDLE.
  - Same write/read ordering as LPC; DATA = 2×size nibbles, bytes ascending.
- SYNC:
  - 0000: ready, proceed.
  - 0101: short wait. Increment the counter; when the count exceeds WAIT_LIMIT → status 2 record, IDLE.
  - 0110: long wait; the counter is held, no limit.
  - 1010: error. Record status 1 after the remaining DATA/TAR are consumed. A read still captures its data nibbles.
  - Any other nibble: status 1 immediately, IDLE.
  - The wait counter clears on each START.
- Abort: lpc_frame=0 in any non-IDLE state → record status 3 with the fields captured so far. The same cycle is treated as a START candidate, so back-to-back abort and new start both work.
- Record: out_clock_enable is high for exactly the one cycle after the edge that sampled the final TAR nibble (or the error/abort edge). Output fields are updated on that same edge. Fields hold until the next record.
- Minimum gap: a new START may be sampled on the edge immediately after the final TAR.
- Width: the nibble shift register is 32 bits; IO addresses are zero-extended; FWH out_addr = {IDSEL, addr[27:0]}.

Decomposition:
- Package lpc_pkg holds:
  - start codes (START_LPC, START_FWH_RD/WR);
  - CT values;
  - SYNC codes (READY, SHORT_WAIT, LONG_WAIT, ERROR);
  - status codes;
  - FSM state enum (IDLE, CTDIR, FWH_IDSEL, ADDR, MSIZE, DATA, TAR1, SYNC, TAR2).
- One sub-module, lpc_nibble_shift: loadable 32-bit shifter with a nibble counter and MSB-first/LSB-first mode. It is used for both address and data capture.

Test Plan:
- IO read 0x7fe5, 3 short waits, data 0x6c → one strobe: ct_dir 0, addr 0x7fe5, data 0x6c, size 1, status 0.
- Mem write 0xdeadbeef data 0xa5 → ct_dir 0110, addr 0xdeadbeef, data 0xa5, size 1, status 0.
- FWH read IDSEL 3, addr 0x0abcdef, MSIZE 0010, bytes 11 22 33 44 → addr 0x30abcdef, data 0x44332211, size 4.
- IO read with SYNC 1010, data 0xff → status 1, data 0xff, one strobe.
- WAIT_LIMIT=4, 5 short waits → status 2 record; the following IO write 0x0080 / 0x01 decodes normally.
- lpc_frame low after the 2nd address nibble, followed by a valid IO read → status 3 record, then a correct status 0 record (2 strobes total).
